two_bit_divider: RTL and testbench
==================================

TWO_BIT_DIVIDER -- requirements
Module: two_bit_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning divisor width in bits; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port c, input, 32 bits: dividend, i.e. the product to be undone.
REQ-005 The block SHALL have port b, input, N bits: divisor.
REQ-006 The block SHALL have port vld, input, 1 bit: c and b are valid this cycle.
REQ-007 The block SHALL have port rdy, output, 1 bit: block idle, will accept a request this cycle.
REQ-008 The block SHALL have port a, output, 16 bits: quotient, low 16 bits.
REQ-009 The block SHALL have port rem, output, N bits: remainder.
REQ-010 The block SHALL have port ovf, output, 1 bit: quotient exceeds 16 bits.
REQ-011 The block SHALL have port dbz, output, 1 bit: divide-by-zero.
REQ-012 The block SHALL have port result_vld, output, 1 bit: a, rem, ovf and dbz are valid.
REQ-013 The block SHALL have port result_rdy, input, 1 bit: consumer accepts the result.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; rdy=1 only in IDLE; result_vld=1 only in DONE.
REQ-015 Accept SHALL occur on vld && rdy at cycle T: c and b are captured, and the captured values are the only ones used; c and b are don't-care afterwards.
REQ-016 If the captured b==0: IDLE->DONE; result_vld at T+1; dbz=1, a=16'hFFFF, rem=0, ovf=0.
REQ-017 If b!=0 (and the fast path does not apply): IDLE->CALC; unsigned restoring division, one quotient bit per cycle, MSB first; 32 iterations, counter 0..31.
REQ-018 The 32nd iteration SHALL move the FSM to DONE; result_vld at T+33.
REQ-019 Partial remainder SHALL be N+1 bits wide, so no intermediate truncation is allowed; final rem < b always.
REQ-020 Quotient SHALL be held internally at 32 bits; a = q[15:0]; ovf = |q[31:16]; dbz=0.
REQ-021 In DONE, outputs SHALL hold stable until result_vld && result_rdy; then DONE->IDLE, with rdy=1 the following cycle. There is no same-cycle re-accept.
REQ-022 vld while not in IDLE SHALL be ignored, with no side effects.
REQ-023 a, rem, ovf and dbz SHALL be registered, and SHALL be 0 outside DONE.
REQ-024 Identity: when dbz=0 and ovf=0, a*b + rem == c.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, counter=0, a=0, rem=0, ovf=0, dbz=0, result_vld=0.
REQ-026 rdy SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-027 rst SHALL take priority over all other inputs; rst in CALC or DONE aborts the operation and produces no result.

Configuration
REQ-028 Macro TWO_BIT_DIV_FASTPATH_EN, when defined: a nonzero b with exactly one set bit at position k SHALL take IDLE->DONE directly.
- result_vld at T+1
- q = c >> k, rem = c & ((1<<k)-1)
- ovf and a derived as in REQ-020
REQ-029 Macro TWO_BIT_DIV_FASTPATH_EN, when undefined: every nonzero b SHALL use CALC with 33-cycle latency. Results SHALL be bit-identical in both builds.

Verification
REQ-030 Basic: N=4, c=42, b=3, result_rdy=1 -> a=14, rem=0, ovf=0, dbz=0; result_vld exactly 33 cycles after accept; rdy=1 one cycle later.
REQ-031 Remainder: c=100, b=7 -> a=14, rem=2; c=32'hFFFFFFFF, b=4'hF -> a=16'h1111, rem=0, ovf=1.
REQ-032 Divide-by-zero: c=123, b=0 -> result_vld at T+1, dbz=1, a=16'hFFFF, rem=0; a vld pulse in DONE is ignored.
REQ-033 Fast path: c=40, b=4 -> a=10, rem=0.
- With TWO_BIT_DIV_FASTPATH_EN: latency 1.
- Without TWO_BIT_DIV_FASTPATH_EN: latency 33.
REQ-034 Backpressure: result_rdy=0 for 10 cycles after result_vld -> a, rem, ovf, dbz and result_vld stable; rdy stays 0; completion occurs on the first result_rdy=1.
REQ-035 Reset mid-op: rst=1 at iteration 15 of c=1000, b=9 -> all outputs 0 the next cycle, rdy=1 after rst drops; a new c=81, b=9 -> a=9, rem=0.

Source files
------------

// File: rtl/two_bit_divider.sv
// Unsigned 32/N restoring divider; optional TWO_BIT_DIV_FASTPATH_EN short-cuts power-of-two divisors.
// Latency: 33 cycles accept-to-result (1 cycle for b==0 or fast-path hits).
// Backpressure: result held in DONE until result_rdy; rdy low for the whole operation.
module two_bit_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  c,
    input  logic [N-1:0] b,
    input  logic         vld,
    output logic         rdy,
    output logic [15:0]  a,
    output logic [N-1:0] rem,
    output logic         ovf,
    output logic         dbz,
    output logic         result_vld,
    input  logic         result_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [31:0]  dvd;
    logic [31:0]  quo;
    logic [N:0]   prem;
    logic [N-1:0] dvs;
    logic [4:0]   cnt;

    logic [N:0]   trial;
    logic         take;
    logic [N:0]   prem_nxt;
    logic [31:0]  quo_nxt;

    // prem stays below dvs, so shifting in one dividend bit always fits in N+1 bits.
    always_comb begin
        trial    = {prem[N-1:0], dvd[31]};
        take     = (trial >= {1'b0, dvs});
        prem_nxt = take ? (trial - {1'b0, dvs}) : trial;
        quo_nxt  = {quo[30:0], take};
    end

`ifdef TWO_BIT_DIV_FASTPATH_EN
    logic         fast_hit;
    logic [31:0]  fast_q;
    logic [N-1:0] fast_r;

    always_comb begin
        fast_hit = (b != '0) && ((b & (b - N'(1))) == '0);
        fast_q   = c;
        fast_r   = '0;
        for (int k = 0; k < N; k++) begin
            if (b[k]) begin
                fast_q = c >> k;
                fast_r = N'(c & ((32'd1 << k) - 32'd1));
            end
        end
    end
`endif

    assign rdy        = (state == IDLE) && !rst;
    assign result_vld = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a     <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
            dvd   <= '0;
            quo   <= '0;
            prem  <= '0;
            dvs   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vld) begin
                        if (b == '0) begin
                            state <= DONE;
                            dbz   <= 1'b1;
                            a     <= 16'hFFFF;
                            rem   <= '0;
                            ovf   <= 1'b0;
`ifdef TWO_BIT_DIV_FASTPATH_EN
                        end else if (fast_hit) begin
                            state <= DONE;
                            a     <= fast_q[15:0];
                            ovf   <= |fast_q[31:16];
                            rem   <= fast_r;
`endif
                        end else begin
                            state <= CALC;
                            dvd   <= c;
                            dvs   <= b;
                            prem  <= '0;
                            quo   <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    dvd  <= dvd << 1;
                    prem <= prem_nxt;
                    quo  <= quo_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        a     <= quo_nxt[15:0];
                        ovf   <= |quo_nxt[31:16];
                        rem   <= prem_nxt[N-1:0];
                    end
                end
                DONE: begin
                    if (result_rdy) begin
                        state <= IDLE;
                        a     <= '0;
                        rem   <= '0;
                        ovf   <= 1'b0;
                        dbz   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_two_bit_divider.sv
// Scoreboard bench for two_bit_divider: directed vectors, expected results queued at accept.
module tb_two_bit_divider;
    localparam int N  = 4;
    localparam int OW = 18 + N;
`ifdef TWO_BIT_DIV_FASTPATH_EN
    localparam int FP = 1;
`else
    localparam int FP = 33;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   c = '0;
    logic [N-1:0]  b = '0;
    logic          vld = 1'b0;
    logic          rdy;
    logic [15:0]   a;
    logic [N-1:0]  rem;
    logic          ovf;
    logic          dbz;
    logic          result_vld;
    logic          result_rdy = 1'b1;
    logic [OW-1:0] outv;

    two_bit_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .c(c), .b(b), .vld(vld), .rdy(rdy),
        .a(a), .rem(rem), .ovf(ovf), .dbz(dbz),
        .result_vld(result_vld), .result_rdy(result_rdy)
    );

    always #5 clk = ~clk;
    assign outv = {a, rem, ovf, dbz};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0]  a;
        logic [N-1:0] rem;
        logic         ovf;
        logic         dbz;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int results_done = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard when a result appears, checks hold-stability and handshake.
    exp_t          cur;
    bit            have = 1'b0;
    bit            in_res = 1'b0;
    bit            chk_rdy = 1'b0;
    logic [OW-1:0] snap;

    always @(negedge clk) begin
        if (result_vld === 1'b1) begin
            if (!in_res) begin
                in_res = 1'b1;
                snap = outv;
                if (sb.size() == 0) begin
                    have = 1'b0;
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    have = 1'b1;
                    chk({cur.name, "_latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end else begin
                chk("hold_stable", 32'(outv), 32'(snap));
            end
            chk("rdy_low_in_done", 32'(rdy), 32'd0);
            if (result_rdy) begin
                if (have) begin
                    chk({cur.name, "_a"}, 32'(a), 32'(cur.a));
                    chk({cur.name, "_rem"}, 32'(rem), 32'(cur.rem));
                    chk({cur.name, "_ovf"}, 32'(ovf), 32'(cur.ovf));
                    chk({cur.name, "_dbz"}, 32'(dbz), 32'(cur.dbz));
                end
                results_done++;
                in_res = 1'b0;
                chk_rdy = 1'b1;
            end
        end else begin
            chk("outputs_zero_outside_done", 32'(outv), 32'd0);
            if (chk_rdy && !rst) chk("rdy_after_done", 32'(rdy), 32'd1);
            chk_rdy = 1'b0;
        end
    end

    task automatic issue(input string name, input logic [31:0] cc, input logic [N-1:0] bb,
                         input logic [15:0] ea, input logic [N-1:0] er, input logic eo,
                         input logic ed, input int lat, input bit push);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        c   = cc;
        b   = bb;
        vld = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1'b1;
                if (push) begin
                    e.a = ea; e.rem = er; e.ovf = eo; e.dbz = ed;
                    e.lat = lat; e.acc = cyc; e.name = name;
                    sb.push_back(e);
                end
                break;
            end
        end
        if (!ok) chk({name, "_accept_timeout"}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        vld = 1'b0;
        c   = $urandom;
        b   = N'($urandom);
    endtask

    task automatic wait_result(input string name, input int n0);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (results_done > n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_result_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run(input string name, input logic [31:0] cc, input logic [N-1:0] bb,
                       input logic [15:0] ea, input logic [N-1:0] er, input logic eo,
                       input logic ed, input int lat);
        int n0;
        n0 = results_done;
        issue(name, cc, bb, ea, er, eo, ed, lat, 1'b1);
        wait_result(name, n0);
    endtask

    task automatic wait_vld(input string name);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (result_vld) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_vld_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", 32'(rdy), 32'd0);
        chk("result_vld_in_reset", 32'(result_vld), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", 32'(rdy), 32'd1);

        run("basic",    32'd42,        4'd3,  16'd14,     4'd0,  1'b0, 1'b0, 33);
        run("rem7",     32'd100,       4'd7,  16'd14,     4'd2,  1'b0, 1'b0, 33);
        run("max",      32'hFFFFFFFF,  4'hF,  16'h1111,   4'd0,  1'b1, 1'b0, 33);
        run("pow2",     32'd40,        4'd4,  16'd10,     4'd0,  1'b0, 1'b0, FP);
        run("b1_ovf",   32'h00010000,  4'd1,  16'd0,      4'd0,  1'b1, 1'b0, FP);
        run("pow2_rem", 32'd45,        4'd8,  16'd5,      4'd5,  1'b0, 1'b0, FP);
        run("zero_dvd", 32'd0,         4'd5,  16'd0,      4'd0,  1'b0, 1'b0, 33);
        run("eq",       32'd15,        4'd15, 16'd1,      4'd0,  1'b0, 1'b0, 33);
        run("lt",       32'd14,        4'd15, 16'd0,      4'd14, 1'b0, 1'b0, 33);

        // Divide-by-zero held in DONE while a stray request is presented.
        result_rdy = 1'b0;
        n0 = results_done;
        issue("dbz", 32'd123, 4'd0, 16'hFFFF, 4'd0, 1'b0, 1'b1, 1, 1'b1);
        wait_vld("dbz");
        @(posedge clk);
        #1;
        c = 32'd5; b = 4'd1; vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vld = 1'b0;
        result_rdy = 1'b1;
        wait_result("dbz", n0);
        repeat (5) @(posedge clk);

        // Ten cycles of backpressure on a CALC result.
        result_rdy = 1'b0;
        n0 = results_done;
        issue("bp", 32'd1000, 4'd9, 16'd111, 4'd1, 1'b0, 1'b0, 33, 1'b1);
        wait_vld("bp");
        repeat (10) @(posedge clk);
        #1 result_rdy = 1'b1;
        wait_result("bp", n0);

        // Reset lands on iteration 15; the aborted operation must never report.
        issue("abort", 32'd1000, 4'd9, 16'd0, 4'd0, 1'b0, 1'b0, 0, 1'b0);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs_zero", 32'(outv), 32'd0);
        chk("abort_result_vld", 32'(result_vld), 32'd0);
        chk("abort_rdy_in_reset", 32'(rdy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_rdy_after_reset", 32'(rdy), 32'd1);
        run("after_abort", 32'd81, 4'd9, 16'd9, 4'd0, 1'b0, 1'b0, 33);

        repeat (40) @(posedge clk);
        chk("queue_empty", 32'(sb.size()), 32'd0);
        chk("results_count", 32'(results_done), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
